// File: rtl/ist_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ist_dispatch_pkg
// Description : Widths, field offsets, FSM encoding and cid helper for ist_dispatch.
// Revision    : 1.0
// ============================================================================
package ist_dispatch_pkg;

    localparam int TID_WIDTH          = 2;
    localparam int CID_WIDTH          = 2;
    localparam int RID_WIDTH          = TID_WIDTH + CID_WIDTH;
    localparam int NUM_TRIGS_WIDTH    = 3;
    localparam int TRIG_IDX_WIDTH     = 8;
    localparam int TRIG_WIDTH         = 16;

    localparam int IST_MEM_REQ_WIDTH  = TRIG_IDX_WIDTH + NUM_TRIGS_WIDTH + RID_WIDTH;
    localparam int IST_MEM_RESP_WIDTH = RID_WIDTH;
    localparam int TRIG_SRAM_DEPTH    = 2 ** (NUM_TRIGS_WIDTH + CID_WIDTH);
    localparam int TRIG_SRAM_AW       = $clog2(TRIG_SRAM_DEPTH);
    localparam int IST_JOB_WIDTH      = 1 + TRIG_WIDTH + RID_WIDTH;

    // Request word {trig_idx, num_trigs, rid}
    localparam int REQ_RID_LSB        = 0;
    localparam int REQ_NUM_LSB        = RID_WIDTH;
    localparam int REQ_IDX_LSB        = RID_WIDTH + NUM_TRIGS_WIDTH;

    // Job word {last, trig, rid}
    localparam int JOB_RID_LSB        = 0;
    localparam int JOB_TRIG_LSB       = RID_WIDTH;
    localparam int JOB_LAST_BIT       = RID_WIDTH + TRIG_WIDTH;

    typedef logic [CID_WIDTH-1:0]       cid_t;
    typedef logic [RID_WIDTH-1:0]       rid_t;
    typedef logic [NUM_TRIGS_WIDTH-1:0] num_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic cid_t rid2cid(input rid_t rid);
        return rid[TID_WIDTH +: CID_WIDTH];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ist_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : ist_dispatch_if
// Description : Stream, SRAM and job-FIFO signals around ist_dispatch.
// Revision    : 1.0
// ============================================================================
interface ist_dispatch_if;
    import ist_dispatch_pkg::*;

    logic                          ist_req_stream_empty_n;
    logic                          ist_req_stream_read;
    logic [IST_MEM_REQ_WIDTH-1:0]  ist_req_stream_dout;
    logic                          ist_mem_req_stream_full_n;
    logic                          ist_mem_req_stream_write;
    logic [IST_MEM_REQ_WIDTH-1:0]  ist_mem_req_stream_din;
    logic                          ist_mem_resp_stream_empty_n;
    logic                          ist_mem_resp_stream_read;
    logic [IST_MEM_RESP_WIDTH-1:0] ist_mem_resp_stream_dout;
    logic                          trig_sram_rd_en;
    logic [TRIG_SRAM_AW-1:0]       trig_sram_addr;
    logic [TRIG_WIDTH-1:0]         trig_sram_rdata;
    logic                          ist_job_stream_full_n;
    logic                          ist_job_stream_write;
    logic [IST_JOB_WIDTH-1:0]      ist_job_stream_din;

    modport master (
        input  ist_req_stream_empty_n,
        output ist_req_stream_read,
        input  ist_req_stream_dout,
        input  ist_mem_req_stream_full_n,
        output ist_mem_req_stream_write,
        output ist_mem_req_stream_din,
        input  ist_mem_resp_stream_empty_n,
        output ist_mem_resp_stream_read,
        input  ist_mem_resp_stream_dout,
        output trig_sram_rd_en,
        output trig_sram_addr,
        input  trig_sram_rdata,
        input  ist_job_stream_full_n,
        output ist_job_stream_write,
        output ist_job_stream_din
    );

    modport slave (
        output ist_req_stream_empty_n,
        input  ist_req_stream_read,
        output ist_req_stream_dout,
        output ist_mem_req_stream_full_n,
        input  ist_mem_req_stream_write,
        input  ist_mem_req_stream_din,
        output ist_mem_resp_stream_empty_n,
        input  ist_mem_resp_stream_read,
        output ist_mem_resp_stream_dout,
        input  trig_sram_rd_en,
        input  trig_sram_addr,
        output trig_sram_rdata,
        output ist_job_stream_full_n,
        input  ist_job_stream_write,
        input  ist_job_stream_din
    );

endinterface
`default_nettype wire

// File: rtl/ist_dispatch_table.sv
`default_nettype none
// ============================================================================
// Module      : ist_dispatch_table
// Description : Per-ray-slot pending bit and triangle count; one write, one clear, two reads.
// Revision    : 1.0
// ============================================================================
module ist_dispatch_table
    import ist_dispatch_pkg::*;
#(
    parameter int DEPTH = 2 ** CID_WIDTH
) (
    input  wire logic clk,
    input  wire logic arst_n,
    input  wire logic i_wr_en,
    input  wire cid_t i_wr_cid,
    input  wire num_t i_wr_cnt,
    input  wire logic i_clr_en,
    input  wire cid_t i_clr_cid,
    input  wire cid_t i_rd0_cid,
    output logic      o_rd0_pending,
    input  wire cid_t i_rd1_cid,
    output logic      o_rd1_pending,
    output num_t      o_rd1_cnt
);

    logic [DEPTH-1:0] r_pending;
    num_t             r_cnt [DEPTH];

    // Write and clear never address the same slot: a write requires the slot idle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_pending <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            if (i_clr_en) begin
                r_pending[i_clr_cid] <= 1'b0;
            end
            if (i_wr_en) begin
                r_pending[i_wr_cid] <= 1'b1;
                r_cnt[i_wr_cid]     <= i_wr_cnt;
            end
        end
    end

    assign o_rd0_pending = r_pending[i_rd0_cid];
    assign o_rd1_pending = r_pending[i_rd1_cid];
    assign o_rd1_cnt     = r_cnt[i_rd1_cid];

endmodule
`default_nettype wire

// File: rtl/ist_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : ist_dispatch
// Description : Forwards leaf requests to IST memory and expands completions into per-triangle jobs.
// Revision    : 1.0
// ============================================================================
module ist_dispatch
    import ist_dispatch_pkg::*;
#(
    parameter int CID_DEPTH = 2 ** CID_WIDTH
) (
    input  wire logic      clk,
    input  wire logic      arst_n,
    ist_dispatch_if.master bus
);

    state_e r_state;
    state_e w_state_nxt;
    rid_t   r_rid;
    num_t   r_n;
    num_t   r_i;
    logic   r_s_valid;
    rid_t   r_s_rid;
    logic   r_s_last;

    rid_t   w_req_rid;
    num_t   w_req_num;
    cid_t   w_req_cid;
    logic   w_req_pending;
    logic   w_fwd_fire;
    rid_t   w_resp_rid;
    logic   w_tbl_pending;
    num_t   w_tbl_cnt;
    logic   w_resp_read;
    logic   w_adv;
    logic   w_rd_en;
    logic   w_last_issue;
    logic   w_job_write;

    assign w_req_rid  = bus.ist_req_stream_dout[REQ_RID_LSB +: RID_WIDTH];
    assign w_req_num  = bus.ist_req_stream_dout[REQ_NUM_LSB +: NUM_TRIGS_WIDTH];
    assign w_req_cid  = rid2cid(w_req_rid);
    assign w_resp_rid = bus.ist_mem_resp_stream_dout;

    // No bypass on a same-cycle clear: the slot is reusable only once the clear has landed.
    assign w_fwd_fire = arst_n && bus.ist_req_stream_empty_n && bus.ist_mem_req_stream_full_n
                        && !w_req_pending;

    assign bus.ist_req_stream_read      = w_fwd_fire;
    assign bus.ist_mem_req_stream_write = w_fwd_fire;
    assign bus.ist_mem_req_stream_din   = w_fwd_fire ? bus.ist_req_stream_dout : '0;

    ist_dispatch_table #(
        .DEPTH         (CID_DEPTH)
    ) u_table (
        .clk           (clk),
        .arst_n        (arst_n),
        .i_wr_en       (w_fwd_fire),
        .i_wr_cid      (w_req_cid),
        .i_wr_cnt      (w_req_num),
        .i_clr_en      (w_job_write && r_s_last),
        .i_clr_cid     (rid2cid(r_s_rid)),
        .i_rd0_cid     (w_req_cid),
        .o_rd0_pending (w_req_pending),
        .i_rd1_cid     (rid2cid(w_resp_rid)),
        .o_rd1_pending (w_tbl_pending),
        .o_rd1_cnt     (w_tbl_cnt)
    );

    // The read stage may refill whenever it is empty or its job leaves this cycle.
    assign w_adv        = !r_s_valid || bus.ist_job_stream_full_n;
    assign w_last_issue = (r_i == r_n - 1'b1);
    assign w_job_write  = arst_n && r_s_valid && bus.ist_job_stream_full_n;

    always_comb begin
        w_state_nxt = r_state;
        w_resp_read = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_resp_read = arst_n && bus.ist_mem_resp_stream_empty_n;
                if (w_resp_read) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_adv) begin
                    w_rd_en = arst_n;
                    if (w_last_issue) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_job_write && r_s_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= ST_IDLE;
            r_rid     <= '0;
            r_n       <= '0;
            r_i       <= '0;
            r_s_valid <= 1'b0;
            r_s_rid   <= '0;
            r_s_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_resp_read) begin
                r_rid <= w_resp_rid;
                r_n   <= w_tbl_cnt;
                r_i   <= '0;
            end else if (w_rd_en) begin
                r_i <= r_i + 1'b1;
            end
            if (w_adv) begin
                r_s_valid <= w_rd_en;
                if (w_rd_en) begin
                    r_s_rid  <= r_rid;
                    r_s_last <= w_last_issue;
                end
            end
        end
    end

    assign bus.ist_mem_resp_stream_read = w_resp_read;
    assign bus.trig_sram_rd_en          = w_rd_en;
    assign bus.trig_sram_addr           = w_rd_en ? {r_i, rid2cid(r_rid)} : '0;
    assign bus.ist_job_stream_write     = w_job_write;
    assign bus.ist_job_stream_din       = w_job_write ? {r_s_last, bus.trig_sram_rdata, r_s_rid} : '0;

    always_ff @(posedge clk) begin
        if (arst_n && w_fwd_fire) begin
            assert (w_req_num != '0);
        end
        if (arst_n && w_resp_read) begin
            assert (w_tbl_pending);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ist_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ist_dispatch
// Description : Scoreboard bench for ist_dispatch: directed requests/responses, queued expectations.
// Revision    : 1.0
// ============================================================================
module tb_ist_dispatch;
    import ist_dispatch_pkg::*;

    logic clk;
    logic arst_n;
    int   checks;
    int   errors;

    logic [IST_MEM_REQ_WIDTH-1:0] exp_mem[$];
    logic [IST_JOB_WIDTH-1:0]     exp_job[$];
    logic [TRIG_WIDTH-1:0]        sram[TRIG_SRAM_DEPTH];

    ist_dispatch_if bus ();

    ist_dispatch #(
        .CID_DEPTH (4)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preloaded SRAM: row a holds 16'hA500 + a; registered read.
    always @(posedge clk) begin
        if (bus.trig_sram_rd_en) begin
            bus.trig_sram_rdata <= sram[bus.trig_sram_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        if (bus.ist_mem_req_stream_write) begin
            if (exp_mem.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_req: got %0h expected none", bus.ist_mem_req_stream_din);
            end else begin
                chk("mem_req", bus.ist_mem_req_stream_din, exp_mem.pop_front());
            end
        end
        if (bus.ist_job_stream_write) begin
            chk("job_while_full", bus.ist_job_stream_full_n, 1'b1);
            if (exp_job.size() == 0) begin
                checks++; errors++;
                $display("FAIL job: got %0h expected none", bus.ist_job_stream_din);
            end else begin
                chk("job", bus.ist_job_stream_din, exp_job.pop_front());
            end
        end
    end

    task automatic send_req(input logic [7:0] idx, input logic [2:0] n, input rid_t rid);
        bus.ist_req_stream_dout    = {idx, n, rid};
        bus.ist_req_stream_empty_n = 1'b1;
        exp_mem.push_back({idx, n, rid});
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.ist_req_stream_read) begin
                @(posedge clk); #1;
                bus.ist_req_stream_empty_n = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL req_timeout: got no read expected read for rid %0h", rid);
        bus.ist_req_stream_empty_n = 1'b0;
    endtask

    task automatic send_resp(input rid_t rid, input int n);
        logic [TRIG_SRAM_AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = {3'(i), rid[TID_WIDTH +: CID_WIDTH]};
            exp_job.push_back({(i == n - 1), 16'hA500 + {11'd0, a}, rid});
        end
        bus.ist_mem_resp_stream_dout    = rid;
        bus.ist_mem_resp_stream_empty_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.ist_mem_resp_stream_read) begin
                @(posedge clk); #1;
                bus.ist_mem_resp_stream_empty_n = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL resp_timeout: got no read expected read for rid %0h", rid);
        bus.ist_mem_resp_stream_empty_n = 1'b0;
    endtask

    task automatic wait_jobs();
        for (int k = 0; k < 300; k++) begin
            if (exp_job.size() == 0) begin
                repeat (2) @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
        end
        checks++; errors++;
        $display("FAIL jobs_timeout: got %0d pending expected 0", exp_job.size());
        exp_job.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_read"},   bus.ist_req_stream_read, 1'b0);
        chk({tag, "_memreq_wr"},  bus.ist_mem_req_stream_write, 1'b0);
        chk({tag, "_memreq_din"}, bus.ist_mem_req_stream_din, '0);
        chk({tag, "_resp_read"},  bus.ist_mem_resp_stream_read, 1'b0);
        chk({tag, "_rd_en"},      bus.trig_sram_rd_en, 1'b0);
        chk({tag, "_job_wr"},     bus.ist_job_stream_write, 1'b0);
        chk({tag, "_job_din"},    bus.ist_job_stream_din, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int last_cyc;
        int rd_cyc;
        logic exp_wr [5];
        checks = 0;
        errors = 0;
        for (int a = 0; a < TRIG_SRAM_DEPTH; a++) begin
            sram[a] = 16'hA500 + 16'(a);
        end
        bus.trig_sram_rdata             = '0;
        arst_n                          = 1'b0;
        bus.ist_req_stream_empty_n      = 1'b0;
        bus.ist_req_stream_dout         = '0;
        bus.ist_mem_req_stream_full_n   = 1'b1;
        bus.ist_mem_resp_stream_empty_n = 1'b0;
        bus.ist_mem_resp_stream_dout    = '0;
        bus.ist_job_stream_full_n       = 1'b1;
        #3;
        chk_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;

        // Single ray, cid 2: three back-to-back jobs, first at pop+2
        send_req(8'd5, 3'd3, 4'h8);
        send_resp(4'h8, 3);
        exp_wr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("single_wr_c%0d", k), bus.ist_job_stream_write, exp_wr[k]);
        end
        wait_jobs();

        // Back-pressure mid-burst, cid 1, n=4
        send_req(8'h10, 3'd4, 4'h4);
        send_resp(4'h4, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.ist_job_stream_full_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.ist_job_stream_full_n = 1'b1;
        wait_jobs();

        // Same-cid hazard: second cid-2 request waits for the last job of the first
        send_req(8'h20, 3'd3, 4'h8);
        bus.ist_req_stream_dout    = {8'h21, 3'd2, 4'hB};
        bus.ist_req_stream_empty_n = 1'b1;
        exp_mem.push_back({8'h21, 3'd2, 4'hB});
        send_resp(4'h8, 3);
        last_cyc = -1;
        rd_cyc   = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ist_req_stream_read) begin
                rd_cyc = k;
                break;
            end
            if (bus.ist_job_stream_write && bus.ist_job_stream_din[JOB_LAST_BIT]) begin
                last_cyc = k;
            end
        end
        @(posedge clk); #1;
        bus.ist_req_stream_empty_n = 1'b0;
        chk("hazard_last_seen", (last_cyc >= 0), 1'b1);
        chk("hazard_accept_cycle", rd_cyc, last_cyc + 1);
        wait_jobs();
        send_resp(4'hB, 2);
        wait_jobs();

        // Interleave: cid 1 (n=2) and cid 3 (n=1), responses in reverse order
        send_req(8'h30, 3'd2, 4'h5);
        send_req(8'h31, 3'd1, 4'hE);
        send_resp(4'hE, 1);
        send_resp(4'h5, 2);
        wait_jobs();

        // Maximum count on cid 0
        send_req(8'hFF, 3'd7, 4'h1);
        send_resp(4'h1, 7);
        wait_jobs();

        // Reset in the middle of a five-job burst on cid 2
        send_req(8'h40, 3'd5, 4'h9);
        send_resp(4'h9, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst_n = 1'b0;
        bus.ist_req_stream_dout    = {8'h44, 3'd1, 4'hA};
        bus.ist_req_stream_empty_n = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        chk("midreset_jobs_left", exp_job.size(), 4);
        exp_job.delete();
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        exp_mem.push_back({8'h44, 3'd1, 4'hA});
        @(negedge clk);
        chk("post_reset_accept", bus.ist_req_stream_read, 1'b1);
        @(posedge clk); #1;
        bus.ist_req_stream_empty_n = 1'b0;
        send_resp(4'hA, 1);
        wait_jobs();

        repeat (3) @(posedge clk);
        chk("mem_req_queue_empty", exp_mem.size(), 0);
        chk("job_queue_empty", exp_job.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
